// File: rtl/fairy_pipeline_ctrl.sv
// Pipeline sequencing controller: turns writeback exceptions/ERETs into a flush and a
// one-cycle PC redirect, and generates load-use stalls from decode.
module fairy_pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exception_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    input  logic        load_use_i,
    input  logic        mem_busy_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        bubble_ex_o,
    output logic        flush_o,
    output logic        pc_redirect_o,
    output logic [31:0] pc_target_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StFlush,
        StRedirect
    } state_e;

    localparam logic [3:0] CntInit = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;
    logic        event_w;

    assign event_w = exception_i | eret_i;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        target_d      = target_q;
        stall_if_o    = 1'b0;
        stall_id_o    = 1'b0;
        bubble_ex_o   = 1'b0;
        flush_o       = 1'b0;
        pc_redirect_o = 1'b0;
        pc_target_o   = target_q;
        busy_o        = (state_q != StRun);

        unique case (state_q)
            StRun: begin
                // Flush is combinational so younger instructions never commit.
                flush_o = event_w;
                if (event_w) begin
                    target_d = exception_i ? EXC_VECTOR : epc_i;
                    if (mem_busy_i) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StFlush;
                        cnt_d   = CntInit;
                    end
                end else if (load_use_i) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                end
            end
            StDrain: begin
                flush_o    = 1'b1;
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                if (!mem_busy_i) begin
                    state_d = StFlush;
                    cnt_d   = CntInit;
                end
            end
            StFlush: begin
                flush_o    = 1'b1;
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StRedirect;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRedirect: begin
                // Flush here kills the wrong-path fetch issued this cycle.
                flush_o       = 1'b1;
                pc_redirect_o = 1'b1;
                state_d       = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            cnt_q    <= 4'd0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_fairy_pipeline_ctrl.sv
// Bench for fairy_pipeline_ctrl: directed scenarios plus random traffic, checked every cycle
// against a schedule-based model, on two instances (FLUSH_CYCLES = 2 and 1).
module tb_fairy_pipeline_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exception = 1'b0;
    logic        eret = 1'b0;
    logic        load_use = 1'b0;
    logic        mem_busy = 1'b0;
    logic [31:0] epc = 32'd0;

    logic        stall_if[2];
    logic        stall_id[2];
    logic        bubble_ex[2];
    logic        flush[2];
    logic        pc_redirect[2];
    logic        busy[2];
    logic [31:0] pc_target[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fairy_pipeline_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .exception_i  (exception),
        .eret_i       (eret),
        .epc_i        (epc),
        .load_use_i   (load_use),
        .mem_busy_i   (mem_busy),
        .stall_if_o   (stall_if[0]),
        .stall_id_o   (stall_id[0]),
        .bubble_ex_o  (bubble_ex[0]),
        .flush_o      (flush[0]),
        .pc_redirect_o(pc_redirect[0]),
        .pc_target_o  (pc_target[0]),
        .busy_o       (busy[0])
    );

    fairy_pipeline_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .exception_i  (exception),
        .eret_i       (eret),
        .epc_i        (epc),
        .load_use_i   (load_use),
        .mem_busy_i   (mem_busy),
        .stall_if_o   (stall_if[1]),
        .stall_id_o   (stall_id[1]),
        .bubble_ex_o  (bubble_ex[1]),
        .flush_o      (flush[1]),
        .pc_redirect_o(pc_redirect[1]),
        .pc_target_o  (pc_target[1]),
        .busy_o       (busy[1])
    );

    function automatic int flush_cycles(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted event schedules a redirect FLUSH_CYCLES+1 cycles after the first
    // cycle (event cycle included) in which memory is seen idle.
    int          cyc = 0;
    bit          model_valid = 1'b0;
    bit          m_active[2] = '{1'b0, 1'b0};
    int          m_redir_at[2] = '{-1, -1};
    logic [31:0] m_tgt[2] = '{32'd0, 32'd0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_active[i]   <= 1'b0;
                m_redir_at[i] <= -1;
                m_tgt[i]      <= 32'd0;
            end else if (!m_active[i]) begin
                if (exception || eret) begin
                    m_active[i]   <= 1'b1;
                    m_tgt[i]      <= exception ? VEC : epc;
                    m_redir_at[i] <= mem_busy ? -1 : cyc + 1 + flush_cycles(i);
                end
            end else if (cyc == m_redir_at[i]) begin
                m_active[i]   <= 1'b0;
                m_redir_at[i] <= -1;
            end else if (m_redir_at[i] < 0 && !mem_busy) begin
                m_redir_at[i] <= cyc + 1 + flush_cycles(i);
            end
        end
        if (reset) model_valid <= 1'b1;
        cyc <= cyc + 1;
    end

    logic e_flush, e_stall, e_bubble, e_redir, e_busy;

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_active[i]) begin
                    e_flush  = exception | eret;
                    e_stall  = load_use & ~(exception | eret);
                    e_bubble = e_stall;
                    e_redir  = 1'b0;
                    e_busy   = 1'b0;
                end else if (cyc == m_redir_at[i]) begin
                    e_flush  = 1'b1;
                    e_stall  = 1'b0;
                    e_bubble = 1'b0;
                    e_redir  = 1'b1;
                    e_busy   = 1'b1;
                end else begin
                    e_flush  = 1'b1;
                    e_stall  = 1'b1;
                    e_bubble = 1'b0;
                    e_redir  = 1'b0;
                    e_busy   = 1'b1;
                end
                chk($sformatf("model_flush%0d", i), 32'(flush[i]), 32'(e_flush));
                chk($sformatf("model_stall_if%0d", i), 32'(stall_if[i]), 32'(e_stall));
                chk($sformatf("model_stall_id%0d", i), 32'(stall_id[i]), 32'(e_stall));
                chk($sformatf("model_bubble%0d", i), 32'(bubble_ex[i]), 32'(e_bubble));
                chk($sformatf("model_redirect%0d", i), 32'(pc_redirect[i]), 32'(e_redir));
                chk($sformatf("model_busy%0d", i), 32'(busy[i]), 32'(e_busy));
                chk($sformatf("model_target%0d", i), pc_target[i], m_tgt[i]);
            end
        end
    end

    task automatic drive(input logic rst, input logic ex, input logic er, input logic lu,
                         input logic mb, input logic [31:0] ep);
        @(posedge clk);
        #1;
        reset     = rst;
        exception = ex;
        eret      = er;
        load_use  = lu;
        mem_busy  = mb;
        epc       = ep;
        @(negedge clk);
    endtask

    int pulses;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("reset_redirect", 32'(pc_redirect[0]), 32'd0);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_target", pc_target[0], 32'd0);

        // Exception at cycle 5, memory idle.
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, c == 5, 1'b0, 1'b0, 1'b0, 32'h1111_2222);
            chk($sformatf("t1_flush_c%0d", c), 32'(flush[0]), 32'(c >= 5 && c <= 8));
            chk($sformatf("t1_redir_c%0d", c), 32'(pc_redirect[0]), 32'(c == 8));
            chk($sformatf("t1_busy_c%0d", c), 32'(busy[0]), 32'(c >= 6 && c <= 8));
            chk($sformatf("t1_f1_redir_c%0d", c), 32'(pc_redirect[1]), 32'(c == 7));
            if (c == 8) chk("t1_target", pc_target[0], 32'hBFC00380);
        end

        // ERET while memory busy for the event cycle plus three more.
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, c == 0, 1'b0, c <= 3, 32'h8000_1234);
            chk($sformatf("t2_redir_c%0d", c), 32'(pc_redirect[0]), 32'(c == 7));
            chk($sformatf("t2_stall_c%0d", c), 32'(stall_if[0]), 32'(c >= 1 && c <= 6));
            if (c == 7) chk("t2_target", pc_target[0], 32'h8000_1234);
        end

        // Exception and ERET together.
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, c == 0, c == 0, 1'b0, 1'b0, 32'h0000_1000);
            chk($sformatf("t3_redir_c%0d", c), 32'(pc_redirect[0]), 32'(c == 3));
            if (c == 3) chk("t3_target", pc_target[0], 32'hBFC00380);
        end

        // Load-use for two cycles, then again with an exception in the second.
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, c < 2, 1'b0, 32'd0);
            chk($sformatf("t4_stall_c%0d", c), 32'(stall_if[0]), 32'(c < 2));
            chk($sformatf("t4_bubble_c%0d", c), 32'(bubble_ex[0]), 32'(c < 2));
            chk($sformatf("t4_flush_c%0d", c), 32'(flush[0]), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("t4b_bubble0", 32'(bubble_ex[0]), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("t4b_bubble1", 32'(bubble_ex[0]), 32'd0);
        chk("t4b_flush1", 32'(flush[0]), 32'd1);
        for (int c = 0; c < 5; c++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Nested exception during FLUSH is dropped.
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, c == 1, c == 0, 1'b0, 1'b0, 32'h8000_0040);
            if (pc_redirect[0]) pulses++;
            if (c == 3) chk("t5_target", pc_target[0], 32'h8000_0040);
        end
        chk("t5_pulses", 32'(pulses), 32'd1);

        // Reset during FLUSH.
        pulses = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int c = 1; c < 7; c++) begin
            drive(c == 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            if (pc_redirect[0]) pulses++;
            if (c == 2) chk("t6_busy", 32'(busy[0]), 32'd0);
        end
        chk("t6_pulses", 32'(pulses), 32'd0);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fairy_pipeline_ctrl.md
# fairy_pipeline_ctrl

Pipeline sequencing controller for the fairy CPU. It turns the writeback stage's exception and ERET events into a pipeline flush and a PC redirect. It also generates load-use stalls from decode. When an exception or ERET arrives, it drains any in-flight data-memory transaction, holds the flush for a programmable number of cycles, then redirects fetch for exactly one cycle.

## Interface

**Parameters**
- `EXC_VECTOR`, default 32'hBFC00380: exception entry PC.
- `FLUSH_CYCLES`, default 2: cycles spent in FLUSH. Legal range 1..15.

**Ports**
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `exception_i`  in  1: exception committed in writeback this cycle.
- `eret_i`  in  1: ERET committed in writeback this cycle.
- `epc_i`  in  32: current CP0 EPC value.
- `load_use_i`  in  1: decode has a load-use hazard against EX.
- `mem_busy_i`  in  1: data-memory transaction outstanding.
- `stall_if_o`  out  1: hold the PC and IF/ID register.
- `stall_id_o`  out  1: hold the ID/EX inputs.
- `bubble_ex_o`  out  1: insert a NOP into EX.
- `flush_o`  out  1: kill the IF, ID, EX and MEM stage contents.
- `pc_redirect_o`  out  1: load `pc_target_o` into the PC.
- `pc_target_o`  out  32: redirect target.
- `busy_o`  out  1: controller is not in RUN.

## Operation

**States.** RUN, DRAIN, FLUSH, REDIRECT. Registers are `state`, `cnt[3:0]` and `target[31:0]`.

**RUN**
- `flush_o` = `exception_i` | `eret_i`, combinational in the same cycle, so younger instructions do not commit.
- If an event is present, latch the target at the edge:
  - `EXC_VECTOR` if `exception_i`;
  - otherwise `epc_i`.
  - Exception has priority when both inputs are high.
- Next state is DRAIN if `mem_busy_i`=1, else FLUSH with `cnt` = `FLUSH_CYCLES`-1.
- With no event and `load_use_i`=1: `stall_if_o` = `stall_id_o` = `bubble_ex_o` = 1.
- An event suppresses the load-use outputs in the same cycle (flush wins).

**DRAIN**
- `flush_o` = `stall_if_o` = `stall_id_o` = 1.
- Stays in DRAIN while `mem_busy_i`=1.
- On the first cycle with `mem_busy_i`=0, goes to FLUSH with `cnt` = `FLUSH_CYCLES`-1.

**FLUSH**
- `flush_o` = `stall_if_o` = `stall_id_o` = 1.
- If `cnt`=0, goes to REDIRECT; otherwise `cnt` decrements.

**REDIRECT**
- `pc_redirect_o`=1, `pc_target_o` = `target`, `flush_o`=1 (kills the wrong-path fetch).
- Stalls are 0.
- Next state is RUN unconditionally.

**Outside RUN**
- `exception_i`, `eret_i` and `load_use_i` are ignored; nested events are dropped.
- `bubble_ex_o`=0.
- `busy_o` = (`state` != RUN).
- `pc_target_o` always shows `target`; it is only meaningful while `pc_redirect_o`=1.

## Timing

**Reset**
- State becomes RUN, `cnt`=0, `target`=0.
- Registered or derived outputs: `pc_redirect_o`=0, `busy_o`=0, `pc_target_o`=0.
- Combinational outputs follow their RUN equations (0 when the inputs are 0).
- Reset asserted in any state returns the controller to RUN at that edge. No redirect is issued afterwards.

**Latency**
- Event at cycle t with `mem_busy_i`=0: FLUSH occupies cycles t+1 .. t+`FLUSH_CYCLES`.
- REDIRECT occurs at t+1+`FLUSH_CYCLES`; RUN resumes the following cycle.
- Each cycle spent in DRAIN adds one cycle.
- `flush_o` is continuously high from t through the REDIRECT cycle.

**Boundary conditions**
- `exception_i` and `eret_i` high together: target is `EXC_VECTOR`.
- `mem_busy_i` that drops in the event cycle itself is sampled high, so the controller enters DRAIN and exits one cycle later.
- `load_use_i` held high continuously produces a continuous stall in RUN; there is no timeout.
- `FLUSH_CYCLES`=1: FLUSH lasts exactly one cycle.

## Test plan

1. Reset, then `exception_i` pulse at cycle 5 with `mem_busy_i`=0 and `FLUSH_CYCLES`=2 → `flush_o`=1 in cycles 5–8; `pc_redirect_o`=1 only in cycle 8 with `pc_target_o`=32'hBFC00380; `busy_o`=1 in cycles 6–8.
2. `eret_i` with `epc_i`=32'h80001234 and `mem_busy_i`=1 for 3 more cycles → DRAIN for 4 cycles, then 2 FLUSH cycles, then redirect to 32'h80001234.
3. `exception_i`=`eret_i`=1 simultaneously with `epc_i`=32'h1000 → redirect target is 32'hBFC00380.
4. `load_use_i`=1 for 2 cycles in RUN → `stall_if_o`/`stall_id_o`/`bubble_ex_o`=1 in exactly those cycles; `flush_o`=0. Repeat with `exception_i` in the second cycle → `bubble_ex_o`=0 and `flush_o`=1 in that cycle.
5. A second `exception_i` during FLUSH → ignored; exactly one `pc_redirect_o` pulse, with `target` unchanged.
6. `reset` asserted during FLUSH → RUN next cycle; `pc_redirect_o` never pulses; `busy_o`=0.
